param_logic_unit: RTL and testbench

- Parametrised, registered successor to the two-input gate blocks. It applies one of eight selectable bitwise gate operations to two WIDTH-bit operands.
- Input and output use a valid/ready handshake with a one-entry output register.
- A built-in sweep FSM generates every operand combination in ascending order and emits the full truth table of the selected gate, as a hardware self-exercise.
- Sits between stimulus sources (switches/bench) and display/monitor logic in lab top-levels.

---
 rtl/param_logic_unit_pkg.sv | 48 ++++
 rtl/param_logic_unit_logic_op_eval.sv | 23 ++
 rtl/param_logic_unit.sv | 183 ++++++++++++++++++
 tb/tb_param_logic_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// param_logic_unit_pkg
// Shared definitions for the parametrised logic unit:
//   - gate-select encodings (OP_AND .. OP_BUF)
//   - sweep FSM state encoding (ST_IDLE, ST_SWEEP, ST_DONE)
//   - logic_eval(): pure bitwise gate function evaluated at MAX_WIDTH bits;
//     callers zero-extend narrower operands and truncate the result.
// -----------------------------------------------------------------------------
package param_logic_unit_pkg;

   localparam int MAX_WIDTH = 8;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_BUF  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bitwise gate; NOT and BUF look only at operand a.
   function automatic logic [MAX_WIDTH-1:0] logic_eval(
      input logic [2:0]           op,
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b
   );
      logic [MAX_WIDTH-1:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         OP_NOT:  r = ~a;
         default: r = a;          // OP_BUF
      endcase
      return r;
   endfunction

endpackage

// File: rtl/param_logic_unit_logic_op_eval.sv
// -----------------------------------------------------------------------------
// logic_op_eval
// Combinational WIDTH-bit gate evaluator wrapping logic_eval().
// Ports:
//   op  in  3      gate select (see param_logic_unit_pkg)
//   a   in  WIDTH  operand A
//   b   in  WIDTH  operand B
//   y   out WIDTH  f(op, a, b)
// -----------------------------------------------------------------------------
module logic_op_eval
   import param_logic_unit_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = WIDTH'(logic_eval(op, MAX_WIDTH'(a), MAX_WIDTH'(b)));

endmodule

// File: rtl/param_logic_unit.sv
// -----------------------------------------------------------------------------
// param_logic_unit
// Registered WIDTH-bit logic unit with valid/ready handshake and a built-in
// truth-table sweep FSM.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   op, a, b, in_valid  operand/op input, accepted when in_valid && in_ready
//   in_ready            IDLE, no sweep request, and output slot free
//   sweep_start         level request for a truth-table sweep (sampled in IDLE)
//   out_valid/out_ready one-entry output register handshake
//   out_a, out_b, y     operands and result held in the output register
//   busy                FSM in SWEEP or DONE
//   done                one-cycle pulse after the last sweep result is taken
//   sig (optional)      16-bit rotate-xor signature of sweep results, present
//                       only when PARAM_LOGIC_UNIT_SIGNATURE_EN is defined
// -----------------------------------------------------------------------------
module param_logic_unit
   import param_logic_unit_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sweep_start,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
   ,
   output logic [15:0]      sig
`endif
);

   localparam int CW = 2 * WIDTH;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       sweep_op_q, sweep_op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] out_a_q, out_a_d;
   logic [WIDTH-1:0] out_b_q, out_b_d;
   logic             done_q, done_d;
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
   logic [15:0]      sig_q, sig_d;
`endif

   logic             slot_free;
   logic             sweeping;
   logic             norm_load;
   logic             sweep_load;
   logic [2:0]       eval_op;
   logic [WIDTH-1:0] eval_a;
   logic [WIDTH-1:0] eval_b;
   logic [WIDTH-1:0] eval_y;

   assign slot_free  = !out_valid_q || out_ready;
   assign sweeping   = (state_q == ST_SWEEP);
   assign in_ready   = (state_q == ST_IDLE) && !sweep_start && slot_free;
   assign norm_load  = in_valid && in_ready;
   assign sweep_load = sweeping && slot_free;

   // One evaluator serves both paths; in SWEEP the counter halves and the
   // latched op replace the external inputs.
   assign eval_op = sweeping ? sweep_op_q : op;
   assign eval_a  = sweeping ? cnt_q[CW-1:WIDTH] : a;
   assign eval_b  = sweeping ? cnt_q[WIDTH-1:0]  : b;

   logic_op_eval #(.WIDTH(WIDTH)) u_eval (
      .op (eval_op),
      .a  (eval_a),
      .b  (eval_b),
      .y  (eval_y)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sweep_op_d  = sweep_op_q;
      out_valid_d = out_valid_q;
      y_d         = y_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      done_d      = 1'b0;
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
      sig_d       = sig_q;
`endif

      // Output register: load, or drain when consumed; data holds on drain.
      if (norm_load || sweep_load) begin
         out_valid_d = 1'b1;
         out_a_d     = eval_a;
         out_b_d     = eval_b;
         y_d         = eval_y;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (sweep_start) begin
               state_d    = ST_SWEEP;
               sweep_op_d = op;
               cnt_d      = '0;
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
               sig_d      = '0;
`endif
            end
         end
         ST_SWEEP: begin
            if (slot_free) begin
               cnt_d = cnt_q + CNT_ONE;
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
               sig_d = {sig_q[14:0], sig_q[15]} ^ 16'(eval_y);
`endif
               if (cnt_q == '1) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Last result taken (or already gone): pulse done as we leave,
            // so busy drops in the same cycle done is high.
            if (slot_free) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         sweep_op_q  <= OP_AND;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         done_q      <= 1'b0;
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
         sig_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sweep_op_q  <= sweep_op_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         done_q      <= done_d;
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
         sig_q       <= sig_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign done      = done_q;
   assign busy      = (state_q != ST_IDLE);
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
   assign sig       = sig_q;
`endif

endmodule

// File: tb/tb_param_logic_unit.sv
// -----------------------------------------------------------------------------
// tb_param_logic_unit
// Self-checking bench for param_logic_unit at WIDTH=2. Expected results come
// from per-op two-input truth tables applied bit by bit, a simple handshake
// model and an ascending-order sweep scoreboard.
// -----------------------------------------------------------------------------
module tb_param_logic_unit;

   localparam int W = 2;
   localparam int NCOMB = 1 << (2 * W);

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         in_valid;
   logic         in_ready;
   logic         sweep_start;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_a, out_b, y;
   logic         busy;
   logic         done;
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
   logic [15:0]  sig;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   param_logic_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .a           (a),
      .b           (b),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sweep_start (sweep_start),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .y           (y),
      .busy        (busy),
      .done        (done)
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
      ,
      .sig         (sig)
`endif
   );

   // Gate truth table: bit index {a,b} -> output bit.
   function automatic logic [W-1:0] ref_gate(input logic [2:0] o,
                                             input logic [W-1:0] x,
                                             input logic [W-1:0] z);
      logic [3:0]   tt;
      logic [W-1:0] r;
      case (o)
         3'd0:    tt = 4'b1000;  // AND
         3'd1:    tt = 4'b1110;  // OR
         3'd2:    tt = 4'b0110;  // XOR
         3'd3:    tt = 4'b0111;  // NAND
         3'd4:    tt = 4'b0001;  // NOR
         3'd5:    tt = 4'b1001;  // XNOR
         3'd6:    tt = 4'b0011;  // NOT a
         default: tt = 4'b1100;  // BUF a
      endcase
      for (int i = 0; i < W; i++) r[i] = tt[{x[i], z[i]}];
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1; op = '0; a = '0; b = '0; in_valid = 1'b0;
      sweep_start = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
      checks++; if (out_a !== '0 || out_b !== '0) begin errors++; $display("FAIL reset_operands got %h/%h want 0/0", out_a, out_b); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
      checks++; if (sig !== 16'h0) begin errors++; $display("FAIL reset_sig got %h want 0", sig); end
`endif
      $display("reset released");
   endtask

   // Back-to-back transfers with the consumer always ready.
   task automatic test_back_to_back();
      logic [W-1:0] ey;
      logic [W-1:0] ea, eb;
      out_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         op = 3'($urandom_range(0, 7));
         a = W'($urandom); b = W'($urandom);
         in_valid = 1'b1;
         ea = a; eb = b; ey = ref_gate(op, a, b);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
         @(posedge clk); @(negedge clk);
         checks++; if (out_valid !== 1'b1 || y !== ey || out_a !== ea || out_b !== eb) begin
            errors++; $display("FAIL b2b_result v=%b y=%h a=%h b=%h want v=1 y=%h a=%h b=%h", out_valid, y, out_a, out_b, ey, ea, eb);
         end
         $display("b2b op=%0d a=%h b=%h y=%h", op, ea, eb, y);
      end
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 1'b0 || y !== ey) begin errors++; $display("FAIL b2b_drain v=%b y=%h want v=0 y=%h", out_valid, y, ey); end
   endtask

   // Result held stable while the consumer stalls.
   task automatic test_stall();
      logic [W-1:0] ey;
      op = 3'd3; a = 2'b10; b = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
      ey = ref_gate(3'd3, 2'b10, 2'b11);
      @(posedge clk); @(negedge clk);
      a = 2'b00; b = 2'b00;              // must not be accepted
      for (int n = 0; n < 3; n++) begin
         checks++; if (out_valid !== 1'b1 || y !== ey || out_a !== 2'b10 || out_b !== 2'b11) begin
            errors++; $display("FAIL stall_hold v=%b y=%h a=%h b=%h want v=1 y=%h a=2 b=3", out_valid, y, out_a, out_b, ey);
         end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_consume got %b want 0", out_valid); end
      $display("stall y=%h consumed", ey);
   endtask

   // Random producer/consumer against a one-entry register model.
   task automatic test_random_handshake();
      bit           m_valid;
      logic [W-1:0] m_y, m_a, m_b;
      bit           exp_ready;
      m_valid = 1'b0; m_y = '0; m_a = '0; m_b = '0;
      for (int n = 0; n < 60; n++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
         a = W'($urandom); b = W'($urandom);
         exp_ready = !m_valid || out_ready;
         #1;
         checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL hs_in_ready got %b want %b", in_ready, exp_ready); end
         if (in_valid && exp_ready) begin
            m_valid = 1'b1; m_a = a; m_b = b; m_y = ref_gate(op, a, b);
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         @(posedge clk); @(negedge clk);
         checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL hs_out_valid got %b want %b", out_valid, m_valid); end
         if (m_valid) begin
            checks++; if (y !== m_y || out_a !== m_a || out_b !== m_b) begin
               errors++; $display("FAIL hs_data y=%h a=%h b=%h want y=%h a=%h b=%h", y, out_a, out_b, m_y, m_a, m_b);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
   endtask

   // Full sweep; optional random back-pressure, op/in_valid/sweep_start noise.
   task automatic test_sweep(input bit random_ready);
      logic [2:0]   sop;
      logic [W-1:0] ea, eb, ey;
      logic [15:0]  msig;
      int           n_res;
      bit           finished;
      in_valid = 1'b0; sweep_start = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      sop = 3'($urandom_range(0, 7));
      op = sop; sweep_start = 1'b1; in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sweep_start_priority in_ready=%b want 0", in_ready); end
      @(posedge clk); @(negedge clk);
      sweep_start = 1'b0; in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL sweep_started busy=%b v=%b want 1/0", busy, out_valid); end
      n_res = 0; msig = '0; finished = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         if (done === 1'b1) begin
            finished = 1'b1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_done_busy got %b want 0", busy); end
            checks++; if (n_res != NCOMB) begin errors++; $display("FAIL sweep_count got %0d want %0d", n_res, NCOMB); end
            $display("sweep op=%0d done after %0d results", sop, n_res);
         end else begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy got %b want 1", busy); end
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            op = 3'($urandom_range(0, 7));
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom);
            sweep_start = (n_res < NCOMB - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (out_valid === 1'b1 && out_ready) begin
               ea = W'(n_res >> W); eb = W'(n_res); ey = ref_gate(sop, ea, eb);
               checks++;
               if (n_res >= NCOMB) begin
                  errors++; $display("FAIL sweep_extra result %0d beyond %0d", n_res, NCOMB);
               end else if (out_a !== ea || out_b !== eb || y !== ey) begin
                  errors++; $display("FAIL sweep_result idx=%0d got a=%h b=%h y=%h want a=%h b=%h y=%h", n_res, out_a, out_b, y, ea, eb, ey);
               end
               $display("sweep result a=%h b=%h y=%h", out_a, out_b, y);
               msig = {msig[14:0], msig[15]} ^ 16'(ey);
               n_res++;
            end
            @(posedge clk); @(negedge clk);
         end
      end
      sweep_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      if (!finished) begin
         checks++; errors++; $display("FAIL sweep_timeout results=%0d no done", n_res);
      end
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
      checks++; if (sig !== msig) begin errors++; $display("FAIL sweep_sig got %h want %h", sig, msig); end
`endif
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); @(negedge clk);
         checks++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL sweep_after done=%b busy=%b v=%b want 0/0/0", done, busy, out_valid);
         end
      end
   endtask

   // Reset part-way through a sweep, then a clean sweep.
   task automatic test_sweep_reset();
      int n_res;
      in_valid = 1'b0; out_ready = 1'b1;
      op = 3'($urandom_range(0, 7)); sweep_start = 1'b1;
      @(posedge clk); @(negedge clk);
      sweep_start = 1'b0;
      n_res = 0;
      for (int cyc = 0; cyc < 50 && n_res < 5; cyc++) begin
         if (out_valid === 1'b1) n_res++;
         if (n_res < 5) begin @(posedge clk); @(negedge clk); end
      end
      checks++; if (n_res != 5) begin errors++; $display("FAIL sweep_rst_progress got %0d want 5", n_res); end
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || y !== '0 || out_a !== '0 || out_b !== '0) begin
         errors++; $display("FAIL sweep_rst_outputs v=%b y=%h a=%h b=%h want zeros", out_valid, y, out_a, out_b);
      end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL sweep_rst_ctrl busy=%b done=%b want 0/0", busy, done); end
`ifdef PARAM_LOGIC_UNIT_SIGNATURE_EN
      checks++; if (sig !== 16'h0) begin errors++; $display("FAIL sweep_rst_sig got %h want 0", sig); end
`endif
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); @(negedge clk);
         checks++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL sweep_rst_quiet done=%b busy=%b v=%b want 0/0/0", done, busy, out_valid);
         end
      end
      $display("reset mid-sweep after %0d results", n_res);
      test_sweep(1'b0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_random_handshake();
      test_sweep(1'b0);
      test_sweep(1'b1);
      test_sweep(1'b1);
      test_sweep_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
